// File: rtl/mmcm_drp_seq.sv
// rtl/mmcm_drp_seq.sv - MMCM DRP transaction sequencer with reset drive and lock wait
// Turns single-cycle register-block strobes into DEN/DRDY handshakes and tracks MMCM lock.
module mmcm_drp_seq #(
    parameter int pDRDY_TIMEOUT = 64,
    parameter int pLOCK_TIMEOUT = 50000,
    parameter int pCNT_WIDTH    = 16
) (
    input  logic        clk_usb,
    input  logic        reset_i,
    input  logic [6:0]  req_addr,
    input  logic [15:0] req_din,
    input  logic        req_den,
    input  logic        req_dwe,
    input  logic        req_reset,
    output logic [15:0] rd_data,
    output logic        busy,
    output logic        timeout,
    output logic        overrun,
    output logic        locked_o,
    output logic [6:0]  mmcm_daddr,
    output logic [15:0] mmcm_di,
    output logic        mmcm_den,
    output logic        mmcm_dwe,
    input  logic [15:0] mmcm_do,
    input  logic        mmcm_drdy,
    output logic        mmcm_rst,
    input  logic        mmcm_locked
);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_ACCESS    = 2'd1;
    localparam logic [1:0] ST_WAIT_DRDY = 2'd2;
    localparam logic [1:0] ST_LOCK_WAIT = 2'd3;

    // Expiry fires on the last counted cycle so each wait lasts exactly the timeout.
    localparam logic [pCNT_WIDTH-1:0] DRDY_LAST = pCNT_WIDTH'(pDRDY_TIMEOUT - 1);
    localparam logic [pCNT_WIDTH-1:0] LOCK_LAST = pCNT_WIDTH'(pLOCK_TIMEOUT - 1);
    localparam logic [pCNT_WIDTH-1:0] CNT_ZERO  = '0;
    localparam logic [pCNT_WIDTH-1:0] CNT_ONE   = pCNT_WIDTH'(1);

    logic [1:0]            r_state;
    logic [pCNT_WIDTH-1:0] r_cnt;
    logic                  r_is_write;
    logic                  r_lock_pending;
    logic                  r_rst_q;
    logic                  r_lock_s1;
    logic                  r_lock_s2;
    logic                  r_den;
    logic                  r_dwe;
    logic [6:0]            r_daddr;
    logic [15:0]           r_di;
    logic [15:0]           r_rd_data;
    logic                  r_timeout;
    logic                  r_overrun;

    logic w_cnt_sat;
    logic w_drdy_expire;
    logic w_lock_expire;
    logic w_release;

    assign w_cnt_sat     = &r_cnt;
    assign w_drdy_expire = (r_cnt == DRDY_LAST);
    assign w_lock_expire = (r_cnt == LOCK_LAST);
    assign w_release     = r_rst_q & ~req_reset;

    always_ff @(posedge clk_usb) begin
        if (reset_i) begin
            r_state        <= ST_IDLE;
            r_cnt          <= CNT_ZERO;
            r_is_write     <= 1'b0;
            r_lock_pending <= 1'b0;
            r_rst_q        <= 1'b0;
            r_lock_s1      <= 1'b0;
            r_lock_s2      <= 1'b0;
            r_den          <= 1'b0;
            r_dwe          <= 1'b0;
            r_daddr        <= 7'd0;
            r_di           <= 16'd0;
            r_rd_data      <= 16'd0;
            r_timeout      <= 1'b0;
            r_overrun      <= 1'b0;
        end else begin
            r_rst_q   <= req_reset;
            r_lock_s1 <= mmcm_locked;
            r_lock_s2 <= r_lock_s1;
            r_den     <= 1'b0;
            if (!w_cnt_sat) begin
                r_cnt <= r_cnt + CNT_ONE;
            end
            if (req_den && (r_state != ST_IDLE)) begin
                r_overrun <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (req_den) begin
                        r_daddr    <= req_addr;
                        r_di       <= req_din;
                        r_dwe      <= req_dwe;
                        r_is_write <= req_dwe;
                        r_den      <= 1'b1;
                        r_timeout  <= 1'b0;
                        r_overrun  <= 1'b0;
                        r_cnt      <= CNT_ZERO;
                        r_state    <= ST_ACCESS;
                    end else if (r_lock_pending) begin
                        r_lock_pending <= 1'b0;
                        r_cnt          <= CNT_ZERO;
                        r_state        <= ST_LOCK_WAIT;
                    end
                end
                ST_ACCESS: begin
                    r_dwe   <= 1'b0;
                    r_cnt   <= CNT_ZERO;
                    r_state <= ST_WAIT_DRDY;
                end
                ST_WAIT_DRDY: begin
                    if (mmcm_drdy || w_drdy_expire) begin
                        if (!mmcm_drdy) begin
                            r_timeout <= 1'b1;
                        end else if (!r_is_write) begin
                            r_rd_data <= mmcm_do;
                        end
                        r_cnt <= CNT_ZERO;
                        // A reset release seen during the access is serviced right after it.
                        if (r_lock_pending) begin
                            r_lock_pending <= 1'b0;
                            r_state        <= ST_LOCK_WAIT;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_LOCK_WAIT: begin
                    if (req_reset) begin
                        r_cnt   <= CNT_ZERO;
                        r_state <= ST_IDLE;
                    end else if (r_lock_s2) begin
                        r_cnt   <= CNT_ZERO;
                        r_state <= ST_IDLE;
                    end else if (w_lock_expire) begin
                        r_timeout <= 1'b1;
                        r_cnt     <= CNT_ZERO;
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    r_cnt   <= CNT_ZERO;
                    r_state <= ST_IDLE;
                end
            endcase

            if (w_release) begin
                r_lock_pending <= 1'b1;
            end
        end
    end

    assign rd_data    = r_rd_data;
    assign busy       = (r_state != ST_IDLE);
    assign timeout    = r_timeout;
    assign overrun    = r_overrun;
    assign locked_o   = r_lock_s2;
    assign mmcm_daddr = r_daddr;
    assign mmcm_di    = r_di;
    assign mmcm_den   = r_den;
    assign mmcm_dwe   = r_dwe;
    assign mmcm_rst   = r_rst_q;

endmodule
